// File: rtl/data_mem_responder.sv
// Data memory responder for the core's load/store port.
// Owns the data RAM, one request at a time, response after a fixed latency.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [2:0]        cap_f3;
    logic [31:0]       cap_wdata;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [31:0]       word_num;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic [31:0]       cur_word;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       load_data;
    logic [31:0]       merged;
    logic              acc_err;
    logic              do_access;

    // Out-of-range word addresses wrap onto the array.
    assign word_num  = 32'(cap_addr[ADDR_W-1:2]) % 32'(DEPTH_WORDS);
    assign idx       = IDX_W'(word_num);
    assign lane      = cap_addr[1:0];
    assign cur_word  = mem[idx];
    assign do_access = (state == WAIT) && (cnt == 4'd0);

    // Lane selection, error decode, load extension and store merge.
    always_comb begin
        sel_byte  = cur_word[7:0];
        sel_half  = lane[1] ? cur_word[31:16] : cur_word[15:0];
        load_data = '0;
        merged    = cur_word;
        acc_err   = 1'b0;
        case (lane)
            2'd0: sel_byte = cur_word[7:0];
            2'd1: sel_byte = cur_word[15:8];
            2'd2: sel_byte = cur_word[23:16];
            2'd3: sel_byte = cur_word[31:24];
            default: sel_byte = cur_word[7:0];
        endcase
        if (cap_we) begin
            case (cap_f3)
                3'b000: begin
                    case (lane)
                        2'd0: merged[7:0]   = cap_wdata[7:0];
                        2'd1: merged[15:8]  = cap_wdata[7:0];
                        2'd2: merged[23:16] = cap_wdata[7:0];
                        2'd3: merged[31:24] = cap_wdata[7:0];
                        default: merged = cur_word;
                    endcase
                end
                3'b001: begin
                    acc_err = lane[0];
                    if (lane[1]) merged[31:16] = cap_wdata[15:0];
                    else         merged[15:0]  = cap_wdata[15:0];
                end
                3'b010: begin
                    acc_err = |lane;
                    merged  = cap_wdata;
                end
                default: acc_err = 1'b1;
            endcase
        end else begin
            case (cap_f3)
                3'b000: load_data = {{24{sel_byte[7]}}, sel_byte};
                3'b001: begin
                    acc_err   = lane[0];
                    load_data = {{16{sel_half[15]}}, sel_half};
                end
                3'b010: begin
                    acc_err   = |lane;
                    load_data = cur_word;
                end
                3'b100: load_data = {24'd0, sel_byte};
                3'b101: begin
                    acc_err   = lane[0];
                    load_data = {16'd0, sel_half};
                end
                default: acc_err = 1'b1;
            endcase
        end
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_access && cap_we && !acc_err) begin
            mem[idx] <= merged;
        end
    end

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_f3    <= '0;
            cap_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_f3    <= req_funct3;
                        cap_wdata <= req_wdata;
                        cnt       <= 4'(LATENCY - 1);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || cap_we) ? 32'd0 : load_data;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
